// File: rtl/data_mem_resp_pkg.sv
// Shared types, constants and the address-check helper for the data-memory
// responder and its storage array.
package data_mem_resp_pkg;

    // Responder sequencing: accept in IDLE, optional wait states, one array
    // access cycle, then a single response cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;

    // A request is in error when it is not word aligned or when its word
    // address falls beyond the end of the array.
    function automatic logic addr_error(input logic [31:0] addr,
                                        input logic [31:0] depth_words);
        logic [31:0] word_addr;
        word_addr = {{ADDR_LSB{1'b0}}, addr[31:ADDR_LSB]};
        return (addr[ADDR_LSB-1:0] != '0) || (word_addr >= depth_words);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. One access per cycle: write when en && we,
// read when en && !we.
module data_mem_array
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane write into the storage array.
    // NOTE: the storage array is deliberately left out of reset; resetting
    // every word would turn the RAM into a flop array and costs a clear cycle
    // the processor never needs.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read; the read register holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the memory stage. Accepts one
// load/store at a time in IDLE, waits WAIT_CYCLES cycles, performs the array
// access, and pulses respValid for one cycle. Every output is either a
// register or a decode of the state register.
module data_mem_responder
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    input  logic        reqWrite,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    input  logic [3:0]  reqByteEn,
    output logic        reqReady,
    output logic [31:0] respRData,
    output logic        respValid,
    output logic        respErr,
    output logic        busy
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    // The counter only ever holds values up to WAIT_CYCLES-1.
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    wait_cnt;
    logic                accept;

    // Request captured at accept time.
    logic                write_q;
    logic                err_q;
    logic [ADDR_W-1:0]   index_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;

    // Response bookkeeping.
    logic                resp_err_q;
    logic                load_sel_q;

    // Array interface.
    logic                ram_en;
    logic [31:0]         ram_rdata;

    assign accept = reqValid && (state == IDLE);

    // State register.
    // NOTE: sequential state is always updated with <= so every flop samples
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded handshake outputs.
    // NOTE: every signal driven here gets a default first so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        reqReady   = 1'b0;
        busy       = 1'b1;
        respValid  = 1'b0;
        case (state)
            IDLE: begin
                reqReady = 1'b1;
                busy     = 1'b0;
                if (accept) begin
                    state_next = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                respValid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Wait-state counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= CNT_LOAD;
        end else if ((state == WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    // Capture the request and its error verdict on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            index_q <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            write_q <= reqWrite;
            err_q   <= addr_error(reqAddr, 32'(DEPTH_WORDS));
            index_q <= reqAddr[ADDR_LSB +: ADDR_W];
            wdata_q <= reqWData;
            be_q    <= reqByteEn;
        end
    end

    // Response flags settle on the access edge and hold until the next one.
    // load_sel_q selects the array read data only for a good load, so errors
    // and stores present zero on respRData.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err_q <= 1'b0;
            load_sel_q <= 1'b0;
        end else if (state == ACCESS) begin
            resp_err_q <= err_q;
            load_sel_q <= !err_q && !write_q;
        end
    end

    // The array is touched only in ACCESS and never for an errored request,
    // so a reset before ACCESS drops a pending store.
    assign ram_en = (state == ACCESS) && !err_q;

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (write_q),
        .addr  (index_q),
        .be    (be_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign respErr   = resp_err_q;
    assign respRData = load_sel_q ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder. Two instances run side by side:
// index 0 with WAIT_CYCLES=2 and index 1 with WAIT_CYCLES=0. A word-array
// model tracks expected memory contents from the load/store rules.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]       req_valid, req_write, req_ready, resp_valid, resp_err, busy;
    logic [1:0][31:0] req_addr, req_wdata, resp_rdata;
    logic [1:0][3:0]  req_be;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] model [2][DEPTH];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        bit          exp_er;
    } vec_t;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
        .clk       (clk),
        .rst       (rst),
        .reqValid  (req_valid[0]),
        .reqWrite  (req_write[0]),
        .reqAddr   (req_addr[0]),
        .reqWData  (req_wdata[0]),
        .reqByteEn (req_be[0]),
        .reqReady  (req_ready[0]),
        .respRData (resp_rdata[0]),
        .respValid (resp_valid[0]),
        .respErr   (resp_err[0]),
        .busy      (busy[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .clk       (clk),
        .rst       (rst),
        .reqValid  (req_valid[1]),
        .reqWrite  (req_write[1]),
        .reqAddr   (req_addr[1]),
        .reqWData  (req_wdata[1]),
        .reqByteEn (req_be[1]),
        .reqReady  (req_ready[1]),
        .respRData (resp_rdata[1]),
        .respValid (resp_valid[1]),
        .respErr   (resp_err[1]),
        .busy      (busy[1])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit exp_err(input logic [31:0] a);
        return ((a % 32'd4) != 0) || ((a / 32'd4) >= 32'(DEPTH));
    endfunction

    // Reference behaviour of one request: updates the word model for a good
    // store and returns the response data/error the block should produce.
    task automatic model_access(input int d, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be,
                                output logic [31:0] rd, output bit er);
        int idx;
        er = exp_err(a);
        rd = '0;
        if (!er) begin
            idx = int'(a / 32'd4);
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[d][idx][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                rd = model[d][idx];
            end
        end
    endtask

    // Drive one request (called at a negedge) and collect the response.
    // lat counts negedges after the accept edge up to the one showing
    // respValid. v_next/r_next are respValid/reqReady one cycle later.
    task automatic do_req(input int d, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic v_next, output logic r_next, output bit ok);
        int n;
        n = 0;
        ok = 1'b1; rd = '0; er = 1'b0; lat = 0; v_next = 1'b0; r_next = 1'b0;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[d] !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (resp_valid[d] !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (resp_valid[d] !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        rd = resp_rdata[d];
        er = resp_err[d];
        @(negedge clk);
        v_next = resp_valid[d];
        r_next = req_ready[d];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        #1;
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (req_ready[d] !== 1'b1 || busy[d] !== 1'b0 || resp_valid[d] !== 1'b0 ||
                resp_rdata[d] !== 32'h0 || resp_err[d] !== 1'b0) begin
                mismatched++;
                $display("FAIL reset[%0d] got ready=%b busy=%b valid=%b rdata=%h err=%b want 1 0 0 00000000 0",
                         d, req_ready[d], busy[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Give every word a known random value so later loads are predictable.
    task automatic init_memories();
        logic [31:0] rd, wd;
        logic er, vn, rn;
        int lat;
        bit ok;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < DEPTH; w++) begin
                wd = $urandom();
                do_req(d, 1'b1, 32'(w * 4), wd, 4'hF, rd, er, lat, vn, rn, ok);
                model[d][w] = wd;
            end
        end
    endtask

    // Runs a directed table on one instance; expectations come from the table.
    task automatic run_vectors(input string name, input int d, input vec_t v[$]);
        logic [31:0] rd, m_rd;
        logic er, vn, rn;
        bit m_er, ok;
        int lat;
        for (int i = 0; i < v.size(); i++) begin
            do_req(d, v[i].wr, v[i].addr, v[i].wd, v[i].be, rd, er, lat, vn, rn, ok);
            model_access(d, v[i].wr, v[i].addr, v[i].wd, v[i].be, m_rd, m_er);
            compared++;
            if (!ok || rd !== v[i].exp_rd) begin
                mismatched++;
                $display("FAIL %s[%0d] rdata got %h want %h (ok=%0d)", name, i, rd, v[i].exp_rd, ok);
            end
            compared++;
            if (!ok || er !== v[i].exp_er) begin
                mismatched++;
                $display("FAIL %s[%0d] err got %b want %b", name, i, er, v[i].exp_er);
            end
            compared++;
            if (!ok || lat != wait_of(d) + 2) begin
                mismatched++;
                $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, wait_of(d) + 2);
            end
        end
    endtask

    task automatic test_store_load();
        vec_t v[$];
        v.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
        v.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
        run_vectors("store_load", 0, v);
    endtask

    task automatic test_partial_store();
        vec_t v[$];
        v.push_back('{1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0});
        v.push_back('{1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0});
        v.push_back('{1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0});
        run_vectors("partial", 0, v);
    endtask

    task automatic test_errors();
        vec_t v[$];
        v.push_back('{1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0});
        v.push_back('{1'b1, 32'h22, 32'hAABBCCDD, 4'hF, 32'h0, 1'b1});
        v.push_back('{1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1});
        v.push_back('{1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0});
        run_vectors("errors", 0, v);
    endtask

    task automatic test_byteen_zero();
        vec_t v[$];
        v.push_back('{1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0});
        v.push_back('{1'b1, 32'h40, 32'h12345678, 4'h0, 32'h0, 1'b0});
        v.push_back('{1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0});
        run_vectors("byteen0", 0, v);
    endtask

    task automatic test_wait_zero();
        vec_t v[$];
        v.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
        v.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
        v.push_back('{1'b1, 32'h3FC, 32'h0BADCAFE, 4'b1000, 32'h0, 1'b0});
        v.push_back('{1'b0, 32'h401, 32'h0, 4'h0, 32'h0, 1'b1});
        run_vectors("wait0", 1, v);
    endtask

    // reqValid held high: accepts only where reqReady is seen, spaced by the
    // peak-throughput period, and busy is the complement of reqReady.
    task automatic test_handshake(input int d);
        int ready_seen, resp_seen, last, n;
        logic [31:0] exp;
        ready_seen = 0; resp_seen = 0; last = -1; n = 0;
        exp = model[d][4];
        req_valid[d] = 1'b1; req_write[d] = 1'b0; req_addr[d] = 32'h10; req_be[d] = 4'h0;
        for (int c = 0; c < 40; c++) begin
            compared++;
            if (busy[d] !== ~req_ready[d]) begin
                mismatched++;
                $display("FAIL hs[%0d] cyc %0d busy got %b want %b", d, c, busy[d], ~req_ready[d]);
            end
            if (resp_valid[d] === 1'b1) begin
                resp_seen++;
                compared++;
                if (resp_rdata[d] !== exp || resp_err[d] !== 1'b0) begin
                    mismatched++;
                    $display("FAIL hs[%0d] rdata got %h/%b want %h/0", d, resp_rdata[d], resp_err[d], exp);
                end
            end
            if (req_ready[d] === 1'b1) begin
                if (last >= 0) begin
                    compared++;
                    if (c - last != wait_of(d) + 3) begin
                        mismatched++;
                        $display("FAIL hs[%0d] accept gap got %0d want %0d", d, c - last, wait_of(d) + 3);
                    end
                end
                last = c;
                ready_seen++;
            end
            @(negedge clk);
        end
        req_valid[d] = 1'b0;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            if (resp_valid[d] === 1'b1) resp_seen++;
            @(negedge clk);
            n++;
        end
        compared++;
        if (resp_seen != ready_seen || ready_seen < 2) begin
            mismatched++;
            $display("FAIL hs[%0d] responses got %0d want %0d", d, resp_seen, ready_seen);
        end
    endtask

    // Asynchronous reset during the wait states of a store drops the store.
    task automatic test_reset_mid();
        logic [31:0] old, rd;
        logic er, vn, rn;
        int lat;
        bit ok;
        old = model[0][12];
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h30;
        req_wdata[0] = ~old; req_be[0] = 4'hF;
        @(posedge clk);
        #2;
        req_valid[0] = 1'b0;
        compared++;
        if (busy[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid busy before reset got %b want 1", busy[0]);
        end
        rst = 1'b1;
        #1;
        compared++;
        if (req_ready[0] !== 1'b1 || busy[0] !== 1'b0 || resp_valid[0] !== 1'b0 ||
            resp_rdata[0] !== 32'h0 || resp_err[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid outputs got ready=%b busy=%b valid=%b rdata=%h err=%b want 1 0 0 00000000 0",
                     req_ready[0], busy[0], resp_valid[0], resp_rdata[0], resp_err[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat, vn, rn, ok);
        compared++;
        if (!ok || rd !== old || er !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid load got %h/%b want %h/0 (ok=%0d)", rd, er, old, ok);
        end
    endtask

    // Random loads/stores, in and out of range, checked against the model,
    // including the single-cycle pulse and back-to-back issue.
    task automatic test_random(input int d, input int count);
        logic [31:0] a, wd, rd, m_rd;
        logic [3:0] be;
        logic er, vn, rn;
        bit wr, m_er, ok;
        int lat, r;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (r < 8) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else            a = $urandom() | 32'h400;
            wr = 1'($urandom_range(0, 1));
            wd = $urandom();
            be = 4'($urandom_range(0, 15));
            do_req(d, wr, a, wd, be, rd, er, lat, vn, rn, ok);
            model_access(d, wr, a, wd, be, m_rd, m_er);
            compared++;
            if (!ok || rd !== m_rd || er !== m_er) begin
                mismatched++;
                $display("FAIL rand[%0d.%0d] wr=%0d addr=%h got %h/%b want %h/%b",
                         d, i, wr, a, rd, er, m_rd, m_er);
            end
            compared++;
            if (!ok || lat != wait_of(d) + 2) begin
                mismatched++;
                $display("FAIL rand[%0d.%0d] latency got %0d want %0d", d, i, lat, wait_of(d) + 2);
            end
            compared++;
            if (!ok || vn !== 1'b0 || rn !== 1'b1) begin
                mismatched++;
                $display("FAIL rand[%0d.%0d] after resp got valid=%b ready=%b want 0 1", d, i, vn, rn);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        init_memories();
        test_store_load();
        test_partial_store();
        test_errors();
        test_byteen_zero();
        test_wait_zero();
        test_handshake(0);
        test_handshake(1);
        test_reset_mid();
        test_random(0, 40);
        test_random(1, 40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout after 500000 time units");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the pipelined processor's memory stage. It accepts one load/store request at a time over a valid/ready handshake, models a configurable access latency, performs byte-enabled word writes or full-word reads on an internal array, and returns a single-cycle response pulse. It is the target-side counterpart to the memory-stage initiator and replaces the zero-latency data memory.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, ≥ 2.
- WAIT_CYCLES, 2: wait states between accept and array access; 0 allowed.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- reqValid  input  1  request present.
- reqWrite  input  1  1 = store, 0 = load.
- reqAddr  input  32  byte address.
- reqWData  input  32  store data.
- reqByteEn  input  4  store byte lanes; bit i enables bits 8i+7:8i.
- reqReady  output  1  high only in IDLE.
- respValid  output  1  one-cycle completion pulse.
- respRData  output  32  load data; held until the next response.
- respErr  output  1  error flag; valid with respValid, held until the next response.
- busy  output  1  high in every state except IDLE.

## Operation
- Reset values: state IDLE; reqReady=1, respValid=0, respRData=0, respErr=0, busy=0; wait counter=0. The array is not reset.
- A request is accepted on an edge where reqValid && reqReady. At acceptance the block captures reqWrite, reqAddr, reqWData and reqByteEn. reqValid outside IDLE is ignored. No request is queued.
- Error check at accept time:
  - err = (reqAddr[1:0] != 0) || (reqAddr[31:2] >= DEPTH_WORDS).
  - Word index = reqAddr[2+$clog2(DEPTH_WORDS)-1:2].
- States:
  - IDLE: on accept, go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise go to ACCESS.
  - WAIT: decrement the counter each cycle; move to ACCESS on the cycle the counter is 0.
  - ACCESS: if there is no error, a store writes the enabled byte lanes at the edge and a load registers the full word into respRData. Go to RESP.
  - RESP: respValid=1 for exactly one cycle, then IDLE.
- Error response:
  - No array write.
  - respRData=0, respErr=1.
- Non-error response: respErr=0. After a store, respRData=0.
- Store with reqByteEn=4'b0000: the array is unchanged and the response is normal (not an error). Loads ignore reqByteEn.
- Asynchronous reset in any state returns to IDLE immediately. A store not yet committed at its ACCESS edge is dropped.

## Timing
- Accept edge = edge A. respValid is high in the cycle after edge A+WAIT_CYCLES+1.
  - This gives a request-to-response latency of WAIT_CYCLES+2 cycles.
  - WAIT_CYCLES=0 gives a 2-cycle latency.
- reqReady returns high in the cycle after the RESP cycle. Peak throughput is one request per WAIT_CYCLES+3 cycles.
- Store data becomes visible to a load accepted after that store's response.
- All outputs are registered or decoded from state only; there is no combinational path from req* to any output.

## Structure
- Package data_mem_resp_pkg holds:
  - the state enum (IDLE, WAIT, ACCESS, RESP);
  - constants WORD_BYTES=4 and ADDR_LSB=2;
  - an error-check function.
- Sub-module data_mem_array is a synchronous single-port RAM: DEPTH_WORDS×32, 4 byte-write enables, registered read. The FSM, capture registers and wait counter live in the top.

## Test plan
- Store with WAIT_CYCLES=2, then a load:
  - Store: addr 0x10, data 0xDEADBEEF, byteEn 4'hF.
  - Load from 0x10 returns 0xDEADBEEF with respErr=0.
  - Each respValid arrives exactly 4 cycles after its accept edge.
- Partial store, then load:
  - Word 0x20 preloaded with 0x11223344; store byteEn 4'b0101, data 0xAABBCCDD.
  - Load from 0x20 returns 0x11BB33DD.
- Misaligned and out-of-range accesses:
  - Store to 0x22, and a load from 0x400 with DEPTH_WORDS=256.
  - Each gives respErr=1 and respRData=0, and the array is unchanged.
- Handshake and WAIT_CYCLES=0:
  - reqValid held high continuously: accepts occur only when reqReady=1; busy is high otherwise.
  - With WAIT_CYCLES=0, latency is 2 cycles.
- Reset mid-operation:
  - Assert rst asynchronously during WAIT of a store to 0x30.
  - Outputs return to their reset values without waiting for a clock edge.
  - A subsequent load from 0x30 returns the old contents.
